// File: rtl/onstate_pkg.sv
// Shared state encodings and widths for the on-state qualifier.
package onstate_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARM  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ON   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DROP = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOCK = 3'd4;

    // True for the states in which the qualified output is asserted.
    function automatic logic is_on_state(input logic [STATE_W-1:0] s);
        return (s == ST_ON) || (s == ST_DROP);
    endfunction

endpackage

// File: rtl/onstate_cnt.sv
// Small saturating counter used for both the delay count and the on-time count.
module onstate_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over load-1, load-1 wins over increment; increment stops at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= CNT_W'(1);
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/onstate_n.sv
// On-state qualifier: debounced, delayed and optionally time-limited enable.
module onstate_n
    import onstate_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int ON_DLY  = 3,
    parameter int OFF_DLY = 2,
    parameter int MAX_ON  = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_do,
    output logic               o_f,
    output logic               o_f_rise,
    output logic               o_f_fall,
    output logic [STATE_W-1:0] o_state,
    output logic [CNT_W-1:0]   o_on_cnt
);

    // Delay parameters must be representable in the counters.
    generate
        if (CNT_W < 1 || CNT_W > 30) begin : g_bad_width
            $fatal(1, "onstate_n: CNT_W out of range");
        end else if (ON_DLY < 0 || ON_DLY >= (1 << CNT_W)) begin : g_bad_on
            $fatal(1, "onstate_n: ON_DLY does not fit CNT_W");
        end else if (OFF_DLY < 0 || OFF_DLY >= (1 << CNT_W)) begin : g_bad_off
            $fatal(1, "onstate_n: OFF_DLY does not fit CNT_W");
        end else if (MAX_ON < 0 || MAX_ON >= (1 << CNT_W)) begin : g_bad_max
            $fatal(1, "onstate_n: MAX_ON does not fit CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] ON_DLY_C  = CNT_W'(ON_DLY);
    localparam logic [CNT_W-1:0] OFF_DLY_C = CNT_W'(OFF_DLY);
    localparam logic [CNT_W-1:0] MAX_ON_C  = CNT_W'(MAX_ON);

    logic [STATE_W-1:0] r_state;
    logic               r_f;
    logic               r_f_rise;
    logic               r_f_fall;
    logic [CNT_W-1:0]   r_on_cnt;

    logic [STATE_W-1:0] w_next;
    logic [CNT_W-1:0]   w_dcnt;
    logic [CNT_W-1:0]   w_ton;
    logic               w_d_load;
    logic               w_d_inc;
    logic               w_d_clr;
    logic               w_t_load;
    logic               w_t_inc;
    logic               w_t_clr;
    logic               w_max_hit;
    logic               w_f_next;

    // dcnt: qualify count in ARM, drop-out count in DROP.
    onstate_cnt #(.CNT_W(CNT_W)) u_dcnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_d_clr),
        .i_load1 (w_d_load),
        .i_inc   (w_d_inc),
        .o_cnt   (w_dcnt)
    );

    // ton: cycles spent in ON/DROP since the last fresh qualification.
    onstate_cnt #(.CNT_W(CNT_W)) u_ton (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_t_clr),
        .i_load1 (w_t_load),
        .i_inc   (w_t_inc),
        .o_cnt   (w_ton)
    );

    // The on-time limit overrides every other transition out of ON/DROP.
    assign w_max_hit = (MAX_ON != 0) && is_on_state(r_state) && (w_ton == MAX_ON_C);

    // Next-state and delay-counter control.
    always_comb begin
        w_next   = r_state;
        w_d_load = 1'b0;
        w_d_inc  = 1'b0;
        if (w_max_hit) begin
            w_next = i_do ? ST_LOCK : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_do) begin
                        if (ON_DLY == 0) begin
                            w_next = ST_ON;
                        end else begin
                            w_next   = ST_ARM;
                            w_d_load = 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (!i_do) begin
                        w_next = ST_IDLE;
                    end else if (w_dcnt == ON_DLY_C) begin
                        w_next = ST_ON;
                    end else begin
                        w_d_inc = 1'b1;
                    end
                end
                ST_ON: begin
                    if (!i_do) begin
                        if (OFF_DLY == 0) begin
                            w_next = ST_IDLE;
                        end else begin
                            w_next   = ST_DROP;
                            w_d_load = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (i_do) begin
                        w_next = ST_ON;
                    end else if (w_dcnt == OFF_DLY_C) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_d_inc = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (!i_do) begin
                        w_next = ST_IDLE;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // Counter housekeeping derived from the chosen transition.
    always_comb begin
        w_d_clr  = !(w_d_load || w_d_inc);
        w_t_load = !is_on_state(r_state) && (w_next == ST_ON);
        w_t_inc  = is_on_state(r_state) && is_on_state(w_next);
        w_t_clr  = !is_on_state(w_next);
        w_f_next = is_on_state(w_next);
    end

    // State, registered output and activation counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_f      <= 1'b0;
            r_f_rise <= 1'b0;
            r_f_fall <= 1'b0;
            r_on_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_f      <= w_f_next;
            r_f_rise <= w_f_next && !r_f;
            r_f_fall <= !w_f_next && r_f;
            if (w_t_load) begin
                r_on_cnt <= r_on_cnt + CNT_W'(1);
            end
        end
    end

    assign o_f      = r_f;
    assign o_f_rise = r_f_rise;
    assign o_f_fall = r_f_fall;
    assign o_state  = r_state;
    assign o_on_cnt = r_on_cnt;

endmodule
